btn_debounce: RTL and testbench

Debounces one asynchronous push-button input. Timing comes from the one-cycle `tick` pulse produced on wrap of the upstream generic counter. The block consumes that tick stream and outputs a clean level plus single-cycle press and release strobes for the control logic. All debounce timing is expressed in ticks, not clocks, so one slow counter can serve several debouncers.

---
 rtl/btn_debounce.sv | 156 +++++++++++++++
 tb/tb_btn_debounce.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - tick-timed push-button debouncer with press/release strobes
// Optional long-press strobe on btn_hold is built only with DEBOUNCE_HOLD_EN defined.
module btn_debounce #(
  parameter int STABLE_TICKS = 4,
  parameter int HOLD_TICKS   = 100
) (
  input  logic clk,
  input  logic rst_,
  input  logic tick,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_hold
);

  localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    CHECK_HIGH = 2'd1,
    IDLE_HIGH  = 2'd2,
    CHECK_LOW  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_sync1;
  logic          r_sync2;
  logic          w_level_nxt;
  logic          w_press_nxt;
  logic          w_release_nxt;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state     <= IDLE_LOW;
      r_cnt       <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      btn_level   <= w_level_nxt;
      btn_press   <= w_press_nxt;
      btn_release <= w_release_nxt;
    end
  end

  // A reverted input wins over a coincident tick; entry cycles only clear the counter.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = btn_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      IDLE_LOW: begin
        if (r_sync2) begin
          w_state_nxt = CHECK_HIGH;
          w_cnt_nxt   = '0;
        end
      end
      CHECK_HIGH: begin
        if (!r_sync2) begin
          w_state_nxt = IDLE_LOW;
        end else if (tick) begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = IDLE_HIGH;
            w_level_nxt = 1'b1;
            w_press_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
      end
      IDLE_HIGH: begin
        if (!r_sync2) begin
          w_state_nxt = CHECK_LOW;
          w_cnt_nxt   = '0;
        end
      end
      CHECK_LOW: begin
        if (r_sync2) begin
          w_state_nxt = IDLE_HIGH;
        end else if (tick) begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt   = IDLE_LOW;
            w_level_nxt   = 1'b0;
            w_release_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef DEBOUNCE_HOLD_EN
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  logic [HW-1:0] r_hold_cnt;
  logic [HW-1:0] w_hold_cnt_nxt;
  logic          w_hold_nxt;

  // Counter saturates at HOLD_TICKS so one press yields at most one hold strobe;
  // it is left untouched in CHECK_LOW so a bounce back resumes the count.
  always_comb begin
    w_hold_cnt_nxt = r_hold_cnt;
    w_hold_nxt     = 1'b0;
    if (w_press_nxt || w_release_nxt) begin
      w_hold_cnt_nxt = '0;
    end else if ((r_state == IDLE_HIGH) && r_sync2 && tick && (r_hold_cnt != HOLD_MAX)) begin
      w_hold_cnt_nxt = r_hold_cnt + HOLD_ONE;
      w_hold_nxt     = (r_hold_cnt == HOLD_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_hold_cnt <= '0;
      btn_hold   <= 1'b0;
    end else begin
      r_hold_cnt <= w_hold_cnt_nxt;
      btn_hold   <= w_hold_nxt;
    end
  end
`else
  // Keeps HOLD_TICKS referenced when the hold logic is compiled out.
  logic w_unused_hold_cfg;
  assign w_unused_hold_cfg = (HOLD_TICKS > 0);
  assign btn_hold = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - directed self-checking bench for btn_debounce
module tb_btn_debounce;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  logic tick = 1'b0;
  logic btn_in = 1'b0;
  logic btn_level;
  logic btn_press;
  logic btn_release;
  logic btn_hold;

  int   n_checks = 0;
  int   n_pass = 0;
  int   tcnt = 0;
  logic tick_at_edge = 1'b0;

  btn_debounce #(.STABLE_TICKS(4), .HOLD_TICKS(3)) dut (
    .clk(clk),
    .rst_(rst_),
    .tick(tick),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_hold(btn_hold)
  );

  always #5 clk = ~clk;

  // Upstream counter with T=10: tick is high for exactly one posedge in ten.
  always @(negedge clk) begin
    tcnt = (tcnt == 9) ? 0 : tcnt + 1;
    tick = (tcnt == 9);
  end

  task automatic step();
    @(posedge clk);
    tick_at_edge = tick;
    @(negedge clk);
  endtask

  // Runs past the 3 entry edges, then until n ticks have been counted; returns
  // at the negedge after the n-th counted tick. Counts any early output activity.
  task automatic accept_run(input logic start_lvl, input int n,
                            output int pre_bad, output int timed_out);
    int t;
    int guard;
    t = 0;
    guard = 0;
    pre_bad = 0;
    timed_out = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (btn_press || btn_release || (btn_level !== start_lvl)) pre_bad++;
    end
    while (t < n) begin
      step();
      guard++;
      if (tick_at_edge) t++;
      if (t < n && (btn_press || btn_release || (btn_level !== start_lvl))) pre_bad++;
      if (guard > 200) begin
        timed_out = 1;
        t = n;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    int to;
    rst_ = 1'b0;
    btn_in = 1'b1;
    repeat (5) step();
    n_checks++;
    if ({btn_level, btn_press, btn_release, btn_hold} !== 4'b0000)
      $display("FAIL reset_outputs: got %b expected 0000", {btn_level, btn_press, btn_release, btn_hold});
    else n_pass++;
    rst_ = 1'b1;
    accept_run(1'b0, 4, bad, to);
    n_checks++;
    if (to !== 0 || bad !== 0) $display("FAIL reset_early_press: got bad=%0d timeout=%0d expected 0 0", bad, to);
    else n_pass++;
    n_checks++;
    if ({btn_level, btn_press, btn_release} !== 3'b110)
      $display("FAIL reset_first_press: got %b expected 110", {btn_level, btn_press, btn_release});
    else n_pass++;
    step();
    n_checks++;
    if ({btn_level, btn_press} !== 2'b10) $display("FAIL reset_press_width: got %b expected 10", {btn_level, btn_press});
    else n_pass++;
  endtask

  task automatic test_release_reset();
    int bad;
    int to;
    int act;
    btn_in = 1'b0;
    accept_run(1'b1, 4, bad, to);
    n_checks++;
    if (to !== 0 || bad !== 0) $display("FAIL release_early: got bad=%0d timeout=%0d expected 0 0", bad, to);
    else n_pass++;
    n_checks++;
    if ({btn_level, btn_press, btn_release} !== 3'b001)
      $display("FAIL release_strobe: got %b expected 001", {btn_level, btn_press, btn_release});
    else n_pass++;
    step();
    n_checks++;
    if ({btn_level, btn_release} !== 2'b00) $display("FAIL release_width: got %b expected 00", {btn_level, btn_release});
    else n_pass++;
    btn_in = 1'b1;
    accept_run(1'b0, 4, bad, to);
    step();
    btn_in = 1'b0;
    accept_run(1'b1, 2, bad, to);
    n_checks++;
    if (btn_level !== 1'b1 || bad !== 0) $display("FAIL midrelease_level: got level=%b bad=%0d expected 1 0", btn_level, bad);
    else n_pass++;
    rst_ = 1'b0;
    #1;
    n_checks++;
    if ({btn_level, btn_press, btn_release, btn_hold} !== 4'b0000)
      $display("FAIL async_reset: got %b expected 0000", {btn_level, btn_press, btn_release, btn_hold});
    else n_pass++;
    step();
    step();
    rst_ = 1'b1;
    act = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (btn_level || btn_press || btn_release) act++;
    end
    n_checks++;
    if (act !== 0) $display("FAIL post_reset_idle: got %0d active cycles expected 0", act);
    else n_pass++;
  endtask

  task automatic test_collision();
    int bad;
    int to;
    int act;
    btn_in = 1'b1;
    accept_run(1'b0, 3, bad, to);
    act = bad;
    repeat (7) begin
      step();
      if (btn_press || btn_level) act++;
    end
    btn_in = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({btn_level, btn_press, btn_release} !== 3'b000 || act !== 0)
      $display("FAIL collision_no_press: got %b early=%0d expected 000 0", {btn_level, btn_press, btn_release}, act);
    else n_pass++;
    act = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (btn_level || btn_press || btn_release) act++;
    end
    n_checks++;
    if (act !== 0) $display("FAIL collision_idle: got %0d active cycles expected 0", act);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int bad;
    int to;
    int act;
    act = 0;
    btn_in = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      if (btn_level || btn_press || btn_release) act++;
    end
    btn_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (btn_level || btn_press || btn_release) act++;
    end
    n_checks++;
    if (act !== 0) $display("FAIL bounce_quiet: got %0d active cycles expected 0", act);
    else n_pass++;
    btn_in = 1'b1;
    accept_run(1'b0, 4, bad, to);
    n_checks++;
    if (to !== 0 || bad !== 0 || {btn_level, btn_press, btn_release} !== 3'b110)
      $display("FAIL bounce_press: got %b bad=%0d timeout=%0d expected 110 0 0",
               {btn_level, btn_press, btn_release}, bad, to);
    else n_pass++;
    step();
    btn_in = 1'b0;
    accept_run(1'b1, 4, bad, to);
    n_checks++;
    if ({btn_level, btn_press, btn_release} !== 3'b001)
      $display("FAIL bounce_release: got %b expected 001", {btn_level, btn_press, btn_release});
    else n_pass++;
    step();
  endtask

  task automatic test_hold();
    int bad;
    int to;
    int t;
    int guard;
    int holds;
    int hold_at;
    int lvl_bad;
    int exp_holds;
    int exp_at;
`ifdef DEBOUNCE_HOLD_EN
    exp_holds = 1;
    exp_at = 3;
`else
    exp_holds = 0;
    exp_at = -1;
`endif
    btn_in = 1'b1;
    accept_run(1'b0, 4, bad, to);
    n_checks++;
    if ({btn_level, btn_press, btn_hold} !== 3'b110)
      $display("FAIL hold_accept: got %b expected 110", {btn_level, btn_press, btn_hold});
    else n_pass++;
    t = 0;
    guard = 0;
    holds = 0;
    hold_at = -1;
    lvl_bad = 0;
    while (t < 8 && guard < 200) begin
      step();
      guard++;
      if (tick_at_edge) t++;
      if (btn_hold) begin
        holds++;
        hold_at = t;
      end
      if (btn_level !== 1'b1 || btn_release) lvl_bad++;
    end
    n_checks++;
    if (holds !== exp_holds || hold_at !== exp_at || lvl_bad !== 0)
      $display("FAIL hold_pulse: got count=%0d at_tick=%0d lvl_bad=%0d expected %0d %0d 0",
               holds, hold_at, lvl_bad, exp_holds, exp_at);
    else n_pass++;
    btn_in = 1'b0;
    accept_run(1'b1, 4, bad, to);
    n_checks++;
    if ({btn_level, btn_release, btn_hold} !== 3'b010)
      $display("FAIL hold_release: got %b expected 010", {btn_level, btn_release, btn_hold});
    else n_pass++;
    step();
  endtask

  task automatic test_clean_press();
    int bad;
    int to;
    btn_in = 1'b1;
    accept_run(1'b0, 4, bad, to);
    n_checks++;
    if (to !== 0 || bad !== 0) $display("FAIL press_early: got bad=%0d timeout=%0d expected 0 0", bad, to);
    else n_pass++;
    n_checks++;
    if ({btn_level, btn_press, btn_release} !== 3'b110)
      $display("FAIL press_strobe: got %b expected 110", {btn_level, btn_press, btn_release});
    else n_pass++;
    step();
    n_checks++;
    if ({btn_level, btn_press, btn_release} !== 3'b100)
      $display("FAIL press_width: got %b expected 100", {btn_level, btn_press, btn_release});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_release_reset();
    test_collision();
    test_bounce();
    test_hold();
    test_clean_press();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
